anton_neopixel_stream: RTL and testbench
========================================

// Module: anton_neopixel_stream
// PURPOSE
//  Frame serializer that sits directly downstream of anton_neopixel_registers.
//  Walks the pixel buffer byte by byte and drives the single-wire NeoPixel
//  (WS2812) line. Appends the latch/reset low period after the data and raises
//  stream_sync_of so the register block can re-arm or clear run.
// PARAMETERS
//  BUFFER_END    `BUFFER_END_DEFAULT  last valid buffer index (anton_common.vh)
//  BIT_CYCLES    25    clocks per data bit (1.25us at 20MHz)
//  T0H_CYCLES    7     high time of a '0' bit, in clocks
//  T1H_CYCLES    14    high time of a '1' bit, in clocks
//  RESET_CYCLES  1000  low latch period after the last bit, in clocks
// PORTS
//  busClk          in   1   clock, shared with the register block
//  busRst_n        in   1   asynchronous reset, active low
//  pixelAddr       out  BUFFER_BITS  buffer index being read (BUFFER_BITS = CLOG2(BUFFER_END+1))
//  pixelData       in   8   pixels[pixelAddr], combinational, valid in the same cycle
//  reg_max         in   13  last byte index when reg_ctrl_limit=1
//  reg_ctrl_init   in   1   synchronous abort
//  reg_ctrl_limit  in   1   1: last index = reg_max; 0: last index = BUFFER_END
//  reg_ctrl_run    in   1   frame request
//  reg_ctrl_32bit  in   1   4 bytes per pixel; index[1:0]==3 is padding, never sent
//  neoData         out  1   NeoPixel serial line
//  state           out  1   1 while in RESET (latch), else 0
//  stream_sync_of  out  1   one-cycle pulse at the end of the latch period
//  syncStart       out  1   tied 0 (reserved for an external frame trigger)
// BEHAVIOUR
//  - Async reset: FSM=IDLE, pixelAddr=0, neoData=0, state=0, stream_sync_of=0;
//    all counters cleared.
//  - FSM states:
//    IDLE:  pixelAddr=0. When run=1 and init=0, load shift<=pixelData
//           (index 0); go to DATA. First bit's high phase starts the next cycle.
//    DATA:  bit counter 0..BIT_CYCLES-1. neoData=1 while
//           cnt < (bit ? T1H_CYCLES : T0H_CYCLES), else 0. Bytes go out MSB first.
//           After the 8th bit's last cycle, advance the index (+1; in 32bit mode
//           skip indices with [1:0]==3). If the new index > last, go to RESET.
//           Otherwise load shift<=pixelData and continue; there is no gap between bytes.
//    RESET: neoData=0, state=1 for RESET_CYCLES clocks. On the final cycle,
//           stream_sync_of=1 for exactly one cycle; go to IDLE.
//  - last = limit ? min(reg_max, BUFFER_END) : BUFFER_END. Sampled at frame start.
//    32bit is also sampled at frame start. Both stay constant for the whole frame.
//  - reg_max=0 with limit=1 sends exactly 1 byte. In 32bit mode, a last index
//    that lands on a padding byte ends the frame after the preceding byte.
//  - run is only sampled in IDLE. Clearing run mid-frame does not abort; the
//    frame and its latch complete. With loop=1, the register block holds run=1
//    and the next frame starts 1 cycle after the return to IDLE (1 idle cycle).
//  - init=1 in any state: next cycle FSM=IDLE, neoData=0, no stream_sync_of.
//  - Async reset mid-frame: line drops low immediately; no sync pulse.
//  - Widths: bit counter CLOG2(BIT_CYCLES); latch counter CLOG2(RESET_CYCLES);
//    the index is compared with 13-bit zero-extension.
//  - Required: T0H_CYCLES < T1H_CYCLES < BIT_CYCLES; violating this is a
//    $error at elaboration.
// CONFIGURATION
//  ANTON_NEOPIXEL_INVERT_OUT_EN defined: neoData is driven inverted, for an
//    inverting level shifter. Idle/reset level is 1. Internal timing is unchanged.
//  Not defined (default): true polarity; idle/reset level is 0.
// TESTING
//  1 limit=1,max=0,pix[0]=8'hA5,run=1 -> high widths 14,7,14,7,7,14,7,14; each
//    bit 25 clks; then 1000 clks low with state=1; one stream_sync_of pulse.
//  2 limit=0, BUFFER_END=7, 32bit=0 -> 8 bytes = 64 bits (1600 clks) before
//    the latch. With 32bit=1 -> indices 0,1,2,4,5,6 = 48 bits.
//  3 loop=1 with run held 1 -> consecutive frames; exactly 1 IDLE cycle between
//    the sync pulse and the next bit's rising edge.
//  4 init pulse at bit 3 of byte 1 -> neoData=0 the next cycle; FSM IDLE; no sync pulse.
//  5 async reset asserted mid-RESET -> all outputs at reset values immediately.
//    After release with run=0 the block stays idle.
//  6 ANTON_NEOPIXEL_INVERT_OUT_EN defined, repeat test 1 -> waveform is the
//    exact complement; idle level 1.

Source files
------------

// File: rtl/anton_neopixel_stream_if.sv
// rtl/anton_neopixel_stream_if.sv - pixel buffer read port and register-block controls for the frame serializer
interface anton_neopixel_stream_if #(
  parameter int BUFFER_BITS = 9
);
  logic [BUFFER_BITS-1:0] pixelAddr;
  logic [7:0]             pixelData;
  logic [12:0]            reg_max;
  logic                   reg_ctrl_init;
  logic                   reg_ctrl_limit;
  logic                   reg_ctrl_run;
  logic                   reg_ctrl_32bit;
  logic                   stream_sync_of;
  logic                   syncStart;

  // register block side: owns the pixel buffer and the control bits
  modport master (
    output pixelData, reg_max, reg_ctrl_init, reg_ctrl_limit, reg_ctrl_run, reg_ctrl_32bit,
    input  pixelAddr, stream_sync_of, syncStart
  );

  // serializer side
  modport slave (
    input  pixelData, reg_max, reg_ctrl_init, reg_ctrl_limit, reg_ctrl_run, reg_ctrl_32bit,
    output pixelAddr, stream_sync_of, syncStart
  );
endinterface

// File: rtl/anton_neopixel_stream.sv
// rtl/anton_neopixel_stream.sv - WS2812 frame serializer; ANTON_NEOPIXEL_INVERT_OUT_EN inverts neoData
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 511
`endif

module anton_neopixel_stream #(
  parameter int BUFFER_END   = `BUFFER_END_DEFAULT,
  parameter int BIT_CYCLES   = 25,
  parameter int T0H_CYCLES   = 7,
  parameter int T1H_CYCLES   = 14,
  parameter int RESET_CYCLES = 1000
) (
  input  logic                         busClk,
  input  logic                         busRst_n,
  anton_neopixel_stream_if.slave       bus,
  output logic                         neoData,
  output logic                         state
);

  localparam int BUFFER_BITS = (BUFFER_END > 0) ? $clog2(BUFFER_END + 1) : 1;
  localparam int CNT_W       = $clog2(BIT_CYCLES);
  localparam int LATCH_W     = $clog2(RESET_CYCLES);

  localparam logic [13:0]        BUF_LAST   = 14'(BUFFER_END);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   T0H        = CNT_W'(T0H_CYCLES);
  localparam logic [CNT_W-1:0]   T1H        = CNT_W'(T1H_CYCLES);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(RESET_CYCLES - 1);

`ifdef ANTON_NEOPIXEL_INVERT_OUT_EN
  localparam logic INVERT = 1'b1;
`else
  localparam logic INVERT = 1'b0;
`endif

  if (!((T0H_CYCLES < T1H_CYCLES) && (T1H_CYCLES < BIT_CYCLES))) begin : g_bad_timing
    $error("anton_neopixel_stream: need T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_RESET = 2'd2
  } fsm_t;

  fsm_t                fsm_q, fsm_d;
  // idx_q always points at the byte to load next, so pixelData is ready at each byte boundary
  logic [13:0]         idx_q, idx_d;
  logic [13:0]         last_q, last_d;
  logic                m32_q, m32_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_q, bit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LATCH_W-1:0]  latch_q, latch_d;
  logic                neo_q, neo_d;
  logic                sync_q, sync_d;
  logic [13:0]         nxt_idx;
  logic [13:0]         max_ext;

  // next buffer index, hopping over the padding byte of each 32-bit pixel
  function automatic logic [13:0] step_idx(input logic [13:0] cur, input logic mode32);
    logic [13:0] n;
    n = cur + 14'd1;
    if (mode32 && (n[1:0] == 2'b11)) n = cur + 14'd2;
    return n;
  endfunction

  // state register and all counters
  always_ff @(posedge busClk or negedge busRst_n) begin
    if (!busRst_n) begin
      fsm_q   <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      m32_q   <= 1'b0;
      shift_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      latch_q <= '0;
      neo_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      m32_q   <= m32_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      neo_q   <= neo_d;
      sync_q  <= sync_d;
    end
  end

  // next-state logic; line level and sync pulse are decoded from next state so they leave a flop
  always_comb begin
    fsm_d   = fsm_q;
    idx_d   = idx_q;
    last_d  = last_q;
    m32_d   = m32_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    nxt_idx = step_idx(idx_q, m32_q);
    max_ext = {1'b0, bus.reg_max};

    if (bus.reg_ctrl_init) begin
      fsm_d   = ST_IDLE;
      idx_d   = '0;
      bit_d   = '0;
      cnt_d   = '0;
      latch_d = '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          idx_d   = '0;
          bit_d   = '0;
          cnt_d   = '0;
          latch_d = '0;
          if (bus.reg_ctrl_run) begin
            fsm_d   = ST_DATA;
            shift_d = bus.pixelData;
            m32_d   = bus.reg_ctrl_32bit;
            last_d  = (bus.reg_ctrl_limit && (max_ext < BUF_LAST)) ? max_ext : BUF_LAST;
            idx_d   = step_idx(14'd0, bus.reg_ctrl_32bit);
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (bit_q == 3'd7) begin
              bit_d = '0;
              if (idx_q > last_q) begin
                fsm_d   = ST_RESET;
                idx_d   = '0;
                latch_d = '0;
              end else begin
                shift_d = bus.pixelData;
                idx_d   = nxt_idx;
              end
            end else begin
              bit_d   = bit_q + 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RESET: begin
          if (latch_q == LATCH_LAST) begin
            fsm_d   = ST_IDLE;
            latch_d = '0;
          end else begin
            latch_d = latch_q + 1'b1;
          end
        end
        default: fsm_d = ST_IDLE;
      endcase
    end

    neo_d  = (fsm_d == ST_DATA) && (cnt_d < (shift_d[7] ? T1H : T0H));
    sync_d = (fsm_d == ST_RESET) && (latch_d == LATCH_LAST);
  end

  assign bus.pixelAddr      = idx_q[BUFFER_BITS-1:0];
  assign bus.stream_sync_of = sync_q;
  assign bus.syncStart      = 1'b0;
  assign neoData            = neo_q ^ INVERT;
  assign state              = (fsm_q == ST_RESET);

endmodule

// File: tb/tb_anton_neopixel_stream.sv
// tb/tb_anton_neopixel_stream.sv - randomized self-checking bench for anton_neopixel_stream
module tb_anton_neopixel_stream;
  localparam int BE = 7;
  localparam int BC = 25;
  localparam int T0 = 7;
  localparam int T1 = 14;
  localparam int RC = 1000;
`ifdef ANTON_NEOPIXEL_INVERT_OUT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic busClk = 1'b0;
  logic busRst_n = 1'b0;
  logic neoData;
  logic state;
  logic [7:0] pix [0:7];

  int checks = 0;
  int errors = 0;

  bit s_line[$];
  bit s_state[$];
  bit s_sync[$];
  logic [7:0] exp_bytes[$];

  anton_neopixel_stream_if #(.BUFFER_BITS(3)) bus ();
  assign bus.pixelData = pix[bus.pixelAddr];

  anton_neopixel_stream #(.BUFFER_END(BE)) dut (
    .busClk  (busClk),
    .busRst_n(busRst_n),
    .bus     (bus),
    .neoData (neoData),
    .state   (state)
  );

  always #5 busClk = ~busClk;

  task automatic set_ctrl(input bit lim, input int mx, input bit m32);
    bus.reg_ctrl_limit = lim;
    bus.reg_max        = 13'(mx);
    bus.reg_ctrl_32bit = m32;
  endtask

  task automatic randomize_pix();
    for (int i = 0; i < 8; i++) pix[i] = 8'($urandom);
  endtask

  // reference: which bytes a frame must carry, from the last-index and padding rules
  task automatic model_frame(input bit lim, input int mx, input bit m32);
    int last;
    exp_bytes.delete();
    last = lim ? ((mx < BE) ? mx : BE) : BE;
    for (int i = 0; i <= last; i++)
      if (!(m32 && (i % 4) == 3)) exp_bytes.push_back(pix[i]);
  endtask

  task automatic start_frame(input bit hold);
    @(negedge busClk);
    bus.reg_ctrl_run = 1'b1;
    @(posedge busClk);
    #1;
    bus.reg_ctrl_run = hold;
  endtask

  task automatic capture(input string name, input int max_cycles);
    bit got;
    s_line.delete(); s_state.delete(); s_sync.delete();
    got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(negedge busClk);
      s_line.push_back(neoData);
      s_state.push_back(state);
      s_sync.push_back(bus.stream_sync_of);
      got = bus.stream_sync_of;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no sync pulse within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic check_frame(input string name);
    int dlen, elen, b, k, c, n;
    int bad_line, bad_state, bad_sync, f_line, f_state, f_sync;
    logic [7:0] v;
    bit e_line, e_state, e_sync;
    dlen = exp_bytes.size() * 8 * BC;
    elen = dlen + RC;
    checks++;
    if (s_line.size() != elen) begin
      errors++;
      $display("FAIL %s length: got %0d cycles expected %0d", name, s_line.size(), elen);
    end
    bad_line = 0; bad_state = 0; bad_sync = 0; f_line = -1; f_state = -1; f_sync = -1;
    n = (s_line.size() < elen) ? s_line.size() : elen;
    for (int i = 0; i < n; i++) begin
      if (i < dlen) begin
        b = i / (8 * BC);
        k = 7 - ((i / BC) % 8);
        c = i % BC;
        v = exp_bytes[b];
        e_line  = INV ^ (c < (v[k] ? T1 : T0));
        e_state = 1'b0;
        e_sync  = 1'b0;
      end else begin
        e_line  = INV;
        e_state = 1'b1;
        e_sync  = (i == elen - 1);
      end
      if (s_line[i] != e_line)   begin bad_line++;  if (f_line < 0)  f_line = i;  end
      if (s_state[i] != e_state) begin bad_state++; if (f_state < 0) f_state = i; end
      if (s_sync[i] != e_sync)   begin bad_sync++;  if (f_sync < 0)  f_sync = i;  end
    end
    checks++;
    if (bad_line != 0) begin
      errors++;
      $display("FAIL %s neoData: %0d wrong cycles, first at %0d, expected 0 wrong", name, bad_line, f_line);
    end
    checks++;
    if (bad_state != 0) begin
      errors++;
      $display("FAIL %s state: %0d wrong cycles, first at %0d, expected 0 wrong", name, bad_state, f_state);
    end
    checks++;
    if (bad_sync != 0) begin
      errors++;
      $display("FAIL %s sync: %0d wrong cycles, first at %0d, expected 0 wrong", name, bad_sync, f_sync);
    end
  endtask

  task automatic run_and_check(input string name, input bit lim, input int mx, input bit m32);
    set_ctrl(lim, mx, m32);
    model_frame(lim, mx, m32);
    start_frame(1'b0);
    capture(name, 4000);
    check_frame(name);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (neoData !== INV) begin errors++; $display("FAIL %s neoData: got %b expected %b", name, neoData, INV); end
    checks++;
    if (state !== 1'b0) begin errors++; $display("FAIL %s state: got %b expected 0", name, state); end
    checks++;
    if (bus.stream_sync_of !== 1'b0) begin errors++; $display("FAIL %s sync: got %b expected 0", name, bus.stream_sync_of); end
    checks++;
    if (bus.pixelAddr !== 3'd0) begin errors++; $display("FAIL %s pixelAddr: got %0d expected 0", name, bus.pixelAddr); end
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    int act, syn, st;
    act = 0; syn = 0; st = 0;
    repeat (cycles) begin
      @(negedge busClk);
      if (neoData !== INV) act++;
      if (bus.stream_sync_of !== 1'b0) syn++;
      if (state !== 1'b0) st++;
    end
    checks++;
    if (act != 0 || syn != 0 || st != 0) begin
      errors++;
      $display("FAIL %s quiet: active=%0d sync=%0d state=%0d expected all 0", name, act, syn, st);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge busClk);
    check_idle_outputs("reset_held");
    checks++;
    if (bus.syncStart !== 1'b0) begin errors++; $display("FAIL reset syncStart: got %b expected 0", bus.syncStart); end
    busRst_n = 1'b1;
    repeat (3) @(negedge busClk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_single_byte();
    int exp_w[8];
    int w;
    exp_w = '{14, 7, 14, 7, 7, 14, 7, 14};
    pix[0] = 8'hA5;
    run_and_check("single_byte", 1'b1, 0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      w = 0;
      for (int c = 0; c < BC; c++)
        if (k * BC + c < s_line.size() && s_line[k * BC + c] != INV) w++;
      checks++;
      if (w != exp_w[k]) begin
        errors++;
        $display("FAIL single_byte width bit%0d: got %0d expected %0d", k, w, exp_w[k]);
      end
    end
  endtask

  task automatic test_full_buffer();
    randomize_pix();
    run_and_check("full_8bit", 1'b0, 0, 1'b0);
    randomize_pix();
    run_and_check("full_32bit", 1'b0, 0, 1'b1);
    randomize_pix();
    run_and_check("last_on_pad", 1'b1, 3, 1'b1);
    randomize_pix();
    run_and_check("max_over_end", 1'b1, 4000, 1'b0);
  endtask

  task automatic test_random();
    bit lim, m32;
    int mx;
    for (int f = 0; f < 5; f++) begin
      randomize_pix();
      lim = 1'($urandom);
      m32 = 1'($urandom);
      mx  = $urandom_range(0, 10);
      run_and_check($sformatf("random%0d", f), lim, mx, m32);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    randomize_pix();
    set_ctrl(1'b1, 1, 1'b0);
    model_frame(1'b1, 1, 1'b0);
    start_frame(1'b1);
    capture("loop_first", 4000);
    check_frame("loop_first");
    @(negedge busClk);
    checks++;
    if (neoData !== INV || state !== 1'b0) begin
      errors++;
      $display("FAIL loop_gap idle: got neoData=%b state=%b expected %b/0", neoData, state, INV);
    end
    @(negedge busClk);
    bus.reg_ctrl_run = 1'b0;
    checks++;
    if (neoData !== ~INV) begin
      errors++;
      $display("FAIL loop_restart: got neoData=%b expected %b", neoData, ~INV);
    end
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge busClk);
      got = bus.stream_sync_of;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL loop_second sync: got none expected 1 pulse"); end
    watch_quiet("loop_stopped", 60);
  endtask

  task automatic test_init();
    randomize_pix();
    set_ctrl(1'b0, 0, 1'b0);
    start_frame(1'b0);
    repeat (8 * BC + 3 * BC + 4) @(negedge busClk);
    bus.reg_ctrl_init = 1'b1;
    @(negedge busClk);
    check_idle_outputs("init_abort");
    bus.reg_ctrl_init = 1'b0;
    watch_quiet("init_after", 1500);
  endtask

  task automatic test_async_reset();
    randomize_pix();
    set_ctrl(1'b1, 0, 1'b0);
    start_frame(1'b0);
    repeat (8 * BC + 300) @(negedge busClk);
    checks++;
    if (state !== 1'b1) begin errors++; $display("FAIL areset_pre state: got %b expected 1", state); end
    #2;
    busRst_n = 1'b0;
    #1;
    check_idle_outputs("areset_mid_latch");
    @(negedge busClk);
    busRst_n = 1'b1;
    watch_quiet("areset_after", 1200);
  endtask

  initial begin
    bus.reg_ctrl_init  = 1'b0;
    bus.reg_ctrl_run   = 1'b0;
    bus.reg_ctrl_limit = 1'b0;
    bus.reg_ctrl_32bit = 1'b0;
    bus.reg_max        = 13'd0;
    for (int i = 0; i < 8; i++) pix[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_full_buffer();
    test_random();
    test_back_to_back();
    test_init();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
